// File: rtl/tmds_rx_channel.sv
// One TMDS receive lane: hunts control tokens to find the 10-bit word boundary, then decodes data/control.
// Two register stages (align, decode); lock FSM slips the offset on search timeout and drops lock on token gap.
module tmds_rx_channel #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic       pixclk,
  input  logic       resetn,
  input  logic [9:0] raw_word,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       slip
);

  localparam int MAX_TO = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int CW     = $clog2(MAX_TO + 1);
  localparam logic [CW-1:0] C_LOCK = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] C_SRCH = CW'(SEARCH_TIMEOUT);
  localparam logic [CW-1:0] C_LOSS = CW'(LOSS_TIMEOUT);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_TO);

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t        r_state;
  logic [9:0]    r_prev_word;
  logic [9:0]    r_aligned;
  logic [7:0]    r_vd;
  logic [1:0]    r_cd;
  logic          r_vde;
  logic          r_locked;
  logic          r_slip;
  logic [3:0]    r_bit_offset;
  logic [CW-1:0] r_run;
  logic [CW-1:0] r_gap;

  logic [19:0]   w_window;
  logic [9:0]    w_aligned;
  logic          w_tok;
  logic [1:0]    w_cval;
  logic [7:0]    w_x;
  logic [7:0]    w_data;
  logic [CW-1:0] w_run_nxt;
  logic [CW-1:0] w_gap_nxt;

  // Older word occupies the low half: bit 0 of prev_word is the earliest bit received.
  assign w_window  = {raw_word, r_prev_word};
  assign w_aligned = w_window[{1'b0, r_bit_offset} +: 10];

  always_comb begin
    w_tok  = 1'b1;
    w_cval = 2'b00;
    case (r_aligned)
      10'b1101010100: w_cval = 2'b00;
      10'b0010101011: w_cval = 2'b01;
      10'b0101010100: w_cval = 2'b10;
      10'b1010101011: w_cval = 2'b11;
      default:        w_tok  = 1'b0;
    endcase
  end

  assign w_x    = r_aligned[9] ? ~r_aligned[7:0] : r_aligned[7:0];
  assign w_data = {w_x[7:1] ^ w_x[6:0] ^ {7{~r_aligned[8]}}, w_x[0]};

  assign w_run_nxt = !w_tok ? '0 : (r_run == C_LOCK) ? r_run : r_run + 1'b1;
  assign w_gap_nxt = w_tok ? '0 : (r_gap == C_MAX) ? r_gap : r_gap + 1'b1;

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_SEARCH;
      r_prev_word  <= '0;
      r_aligned    <= '0;
      r_vd         <= '0;
      r_cd         <= '0;
      r_vde        <= 1'b0;
      r_locked     <= 1'b0;
      r_slip       <= 1'b0;
      r_bit_offset <= '0;
      r_run        <= '0;
      r_gap        <= '0;
    end else begin
      r_prev_word <= raw_word;
      r_aligned   <= w_aligned;
      if (w_tok) begin
        r_cd  <= w_cval;
        r_vde <= 1'b0;
      end else begin
        r_vd  <= w_data;
        r_vde <= r_locked;
      end
      r_slip <= 1'b0;
      r_run  <= w_run_nxt;
      r_gap  <= w_gap_nxt;
      case (r_state)
        S_SEARCH: begin
          // Lock takes priority over a slip landing on the same cycle.
          if (w_run_nxt == C_LOCK) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end else if (w_gap_nxt == C_SRCH) begin
            r_bit_offset <= (r_bit_offset == 4'd9) ? 4'd0 : r_bit_offset + 4'd1;
            r_slip       <= 1'b1;
            r_run        <= '0;
            r_gap        <= '0;
          end
        end
        S_LOCKED: begin
          // Offset is kept so the first retry after loss is at the old alignment.
          if (w_gap_nxt == C_LOSS) begin
            r_state  <= S_SEARCH;
            r_locked <= 1'b0;
            r_run    <= '0;
            r_gap    <= '0;
          end
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

  assign vd         = r_vd;
  assign cd         = r_cd;
  assign vde        = r_vde & r_locked;
  assign locked     = r_locked;
  assign bit_offset = r_bit_offset;
  assign slip       = r_slip;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: a bit-level serializer feeds TMDS-encoded symbols; a position-based scoreboard checks decode.
module tb_tmds_rx_channel;
  localparam int LC = 8;
  localparam int ST = 2048;
  localparam int LT = 2048;

  logic       pixclk = 1'b0;
  logic       resetn = 1'b1;
  logic [9:0] raw_word = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde, locked, slip;
  logic [3:0] bit_offset;

  tmds_rx_channel #(.LOCK_COUNT(LC), .SEARCH_TIMEOUT(ST), .LOSS_TIMEOUT(LT)) dut (
    .pixclk(pixclk), .resetn(resetn), .raw_word(raw_word), .vd(vd), .cd(cd),
    .vde(vde), .locked(locked), .bit_offset(bit_offset), .slip(slip));

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    bit         chk_vd;
    int         lock_exp;
    int         pos;
  } ent_t;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
  } vec_t;

  ent_t       symq[$];
  ent_t       sb[$];
  bit         bitq[$];
  logic [9:0] tok_tab[4];
  vec_t       tab[9];
  int         pushed, edges, sb_off, n_chk, n_fail, slip_cnt, enc_cnt;
  logic [7:0] m_vd;
  logic [1:0] m_cd;
  bit         m_known;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at word %0d: got 0x%0h, expected 0x%0h", nm, edges, act, exp);
    end
  endtask

  // Reference TMDS encoder with running disparity.
  function automatic logic [9:0] encode(input logic [7:0] d);
    int n1, n1q, n0q;
    bit use_xnor;
    logic [8:0] qm;
    logic [9:0] q;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic push_raw(input logic [9:0] s, input logic [7:0] evd, input logic [1:0] ecd,
                          input logic evde, input bit cvd, input int lk);
    ent_t e;
    e.sym = s; e.vd = evd; e.cd = ecd; e.vde = evde; e.chk_vd = cvd; e.lock_exp = lk; e.pos = 0;
    symq.push_back(e);
  endtask

  task automatic push_data(input logic [7:0] b, input logic evde, input int lk);
    m_vd = b;
    m_known = 1'b1;
    push_raw(encode(b), b, m_cd, evde, 1'b1, lk);
  endtask

  task automatic push_tok(input int v, input int lk);
    m_cd = v[1:0];
    push_raw(tok_tab[v], m_vd, m_cd, 1'b0, m_known, lk);
  endtask

  // Idle line carries token 00; only queued symbols are scoreboarded.
  task automatic refill();
    ent_t e;
    logic [9:0] s;
    if (symq.size() > 0) begin
      e = symq.pop_front();
      e.pos = pushed;
      sb.push_back(e);
      s = e.sym;
    end else begin
      s = tok_tab[0];
    end
    for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
    pushed += 10;
  endtask

  function automatic int emerge(input int pos);
    return (pos - sb_off) / 10 + 3;
  endfunction

  task automatic step();
    logic [9:0] w;
    while (bitq.size() < 10) refill();
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    raw_word = w;
    @(posedge pixclk);
    @(negedge pixclk);
    edges++;
    if (slip === 1'b1) slip_cnt++;
    while (sb.size() > 0 && emerge(sb[0].pos) == edges) begin
      ent_t e;
      e = sb.pop_front();
      chk("vde", vde, e.vde);
      chk("cd", cd, e.cd);
      if (e.chk_vd) chk("vd", vd, e.vd);
      if (e.lock_exp >= 0) chk("locked", locked, e.lock_exp[0]);
    end
  endtask

  task automatic start_stream(input int delay);
    symq.delete(); sb.delete(); bitq.delete();
    edges = 0;
    for (int i = 0; i < delay; i++) bitq.push_back(1'b0);
    pushed = delay;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin step(); n++; end
    chk("drain", sb.size(), 0);
    m_cd = 2'b00;
  endtask

  task automatic wait_locked(input logic v, input int bound, input string nm);
    int n = 0;
    while (locked !== v && n < bound) begin step(); n++; end
    chk(nm, locked, v);
  endtask

  task automatic wait_slip(input int bound, input string nm);
    int s0 = slip_cnt;
    int n = 0;
    while (slip_cnt == s0 && n < bound) begin step(); n++; end
    chk(nm, slip_cnt - s0, 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; enc_cnt = 0; slip_cnt = 0;
    m_vd = '0; m_cd = '0; m_known = 1'b0;
    tok_tab[0] = 10'b1101010100; tok_tab[1] = 10'b0010101011;
    tok_tab[2] = 10'b0101010100; tok_tab[3] = 10'b1010101011;
    tab[0] = '{encode(8'hA5), 8'hA5, 2'b00, 1'b1};
    tab[1] = '{encode(8'h00), 8'h00, 2'b00, 1'b1};
    tab[2] = '{encode(8'hFF), 8'hFF, 2'b00, 1'b1};
    tab[3] = '{10'b0101010100, 8'hFF, 2'b10, 1'b0};
    tab[4] = '{10'b1010101011, 8'hFF, 2'b11, 1'b0};
    tab[5] = '{encode(8'h3C), 8'h3C, 2'b11, 1'b1};
    tab[6] = '{10'b0010101011, 8'h3C, 2'b01, 1'b0};
    tab[7] = '{10'b1101010100, 8'h3C, 2'b00, 1'b0};
    tab[8] = '{encode(8'h81), 8'h81, 2'b00, 1'b1};

    #1 resetn = 1'b0;
    #20;
    chk("rst_vd", vd, 0); chk("rst_cd", cd, 0); chk("rst_vde", vde, 0);
    chk("rst_locked", locked, 0); chk("rst_off", bit_offset, 0); chk("rst_slip", slip, 0);
    @(negedge pixclk) resetn = 1'b1;

    // Acquire with a 3-bit delay: three slips, lock at offset 3.
    start_stream(3);
    slip_cnt = 0;
    wait_locked(1'b1, 4 * ST, "acq3_lock");
    chk("acq3_slips", slip_cnt, 3);
    chk("acq3_off", bit_offset, 3);

    // Random data/control traffic at offset 3.
    sb_off = 3; m_known = 1'b0; m_cd = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) push_tok(int'($urandom_range(0, 3)), 1);
      else push_data(8'($urandom_range(0, 255)), 1'b1, 1);
    end
    drain(500);

    // Asynchronous reset while locked.
    chk("pre_rst_locked", locked, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_vd", vd, 0); chk("arst_cd", cd, 0); chk("arst_vde", vde, 0);
    chk("arst_locked", locked, 0); chk("arst_off", bit_offset, 0); chk("arst_slip", slip, 0);
    #20;
    @(negedge pixclk) resetn = 1'b1;
    chk("rel_off", bit_offset, 0);
    chk("rel_locked", locked, 0);

    // Search restarts at offset 0: a 9-bit delay needs nine slips.
    start_stream(9);
    slip_cnt = 0;
    wait_locked(1'b1, 11 * ST, "acq9_lock");
    chk("acq9_slips", slip_cnt, 9);
    chk("acq9_off", bit_offset, 9);

    // One extra bit: lose lock at offset 9, wrap to 0, relock.
    bitq.push_back(1'b0);
    pushed++;
    slip_cnt = 0;
    wait_locked(1'b0, LT + 50, "wrap_loss");
    chk("wrap_loss_off", bit_offset, 9);
    wait_slip(2 * ST, "wrap_slip");
    chk("wrap_off", bit_offset, 0);
    wait_locked(1'b1, 40, "wrap_relock");
    chk("wrap_slips", slip_cnt, 1);

    // Table-driven data/control decode at offset 0.
    sb_off = 0;
    for (int i = 0; i < 9; i++) push_raw(tab[i].sym, tab[i].vd, tab[i].cd, tab[i].vde, 1'b1, 1);
    drain(40);
    m_vd = 8'h81; m_known = 1'b1;

    // Lock loss after LT non-token words, then qualification 7 tok / data / 8 tok.
    for (int i = 0; i < 3; i++) push_tok(0, 1);
    for (int i = 0; i < LT - 1; i++) push_data(8'($urandom_range(0, 255)), 1'b1, 1);
    push_data(8'h5A, 1'b0, 0);
    for (int i = 0; i < LC - 1; i++) push_tok(0, 0);
    push_data(8'hC3, 1'b0, 0);
    for (int i = 0; i < LC - 1; i++) push_tok(0, 0);
    push_tok(0, 1);
    drain(LT + 100);
    chk("loss_off", bit_offset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
